// File: rtl/fill_batch_sequencer.sv
// Batch supervisor for the bottle filler: issues one startfill per unit, watches the
// llenando/lleno_flag handshake, counts completed units and traps timeouts/protocol errors.
// Optional build macro FILL_SEQ_PAUSE_EN adds a pause input that stretches the inter-unit gap.
module fill_batch_sequencer #(
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] batch_size,
   input  logic             lleno_flag,
   input  logic             llenando,
`ifdef FILL_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   output logic             startfill,
   output logic             busy,
   output logic             batch_done,
   output logic             fault,
   output logic [CNT_W-1:0] units_done,
   output logic [2:0]       seq_state
);

   localparam logic [2:0] S_IDLE  = 3'b000;
   localparam logic [2:0] S_ISSUE = 3'b001;
   localparam logic [2:0] S_WAIT  = 3'b010;
   localparam logic [2:0] S_GAP   = 3'b011;
   localparam logic [2:0] S_DONE  = 3'b100;
   localparam logic [2:0] S_FAULT = 3'b101;

   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [TW-1:0]    r_timer;
   logic [GW-1:0]    r_gap;
   logic [CNT_W-1:0] r_size;
   logic [CNT_W-1:0] r_units;
   logic             r_seen;
   logic             w_pause;
   logic             w_abortHit;
   logic             w_fillSeen;
   logic             w_unitOk;
   logic [CNT_W-1:0] w_newCount;
   logic             w_lastUnit;

`ifdef FILL_SEQ_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   // A completion only counts if the filler was seen filling at some point in this WAIT.
   assign w_abortHit = abort && (r_state != S_IDLE);
   assign w_fillSeen = r_seen | llenando;
   assign w_unitOk   = lleno_flag & w_fillSeen;
   assign w_newCount = (r_units == r_size) ? r_units : r_units + 1'b1;
   assign w_lastUnit = (w_newCount == r_size);

   always_comb begin
      w_next = r_state;
      if (w_abortHit) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_next = (batch_size == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
               if (lleno_flag) begin
                  if (!w_fillSeen) begin
                     w_next = S_FAULT;
                  end else begin
                     w_next = w_lastUnit ? S_DONE : S_GAP;
                  end
               end else if (r_timer == TIMER_LAST) begin
                  w_next = S_FAULT;
               end
            end
            S_GAP: begin
               if (!w_pause && (r_gap == '0)) begin
                  w_next = S_ISSUE;
               end
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_gap   <= '0;
         r_size  <= '0;
         r_units <= '0;
         r_seen  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (!w_abortHit) begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_units <= '0;
                     r_size  <= batch_size;
                  end
               end
               S_ISSUE: begin
                  r_timer <= '0;
                  r_seen  <= 1'b0;
               end
               S_WAIT: begin
                  r_timer <= r_timer + 1'b1;
                  if (llenando) begin
                     r_seen <= 1'b1;
                  end
                  if (w_unitOk) begin
                     r_units <= w_newCount;
                     r_gap   <= GAP_LOAD;
                  end
               end
               S_GAP: begin
                  if (!w_pause && (r_gap != '0)) begin
                     r_gap <= r_gap - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign startfill  = (r_state == S_ISSUE);
   assign busy       = (r_state != S_IDLE) && (r_state != S_FAULT);
   assign batch_done = (r_state == S_DONE);
   assign fault      = (r_state == S_FAULT);
   assign units_done = r_units;
   assign seq_state  = r_state;

endmodule

// File: tb/tb_fill_batch_sequencer.sv
// Directed bench for fill_batch_sequencer with a small cycle-based filler model.
// Define FILL_SEQ_PAUSE_EN for both files to also exercise the gap pause.
module tb_fill_batch_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] batchSize;
   logic       llenoFlag;
   logic       llenando;
`ifdef FILL_SEQ_PAUSE_EN
   logic       pause;
`endif
   logic       startfill;
   logic       busy;
   logic       batch_done;
   logic       fault;
   logic [7:0] units_done;
   logic [2:0] seq_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int since;
   int np;
   int pulseCyc[8];
   int unitsAtPulse[8];
   int lastLleno;
   int doneCyc;
   int doneCount;
   int unitsAtDone;
   int waitEnter;
   int faultCyc;
   int found;

   fill_batch_sequencer #(.CNT_W(8), .TIMEOUT(16), .GAP_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .batch_size (batchSize),
      .lleno_flag (llenoFlag),
      .llenando   (llenando),
`ifdef FILL_SEQ_PAUSE_EN
      .pause      (pause),
`endif
      .startfill  (startfill),
      .busy       (busy),
      .batch_done (batch_done),
      .fault      (fault),
      .units_done (units_done),
      .seq_state  (seq_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      since       = -1;
      np          = 0;
      lastLleno   = -1;
      doneCyc     = -1;
      doneCount   = 0;
      unitsAtDone = -1;
      waitEnter   = -1;
      faultCyc    = -1;
      found       = 0;
      llenando    = 1'b0;
      llenoFlag   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pulseCyc[i]     = -1;
         unitsAtPulse[i] = -1;
      end
   endtask

   task automatic applyStimulus(input logic st, input logic ab, input logic [7:0] sz);
      start     = st;
      abort     = ab;
      batchSize = sz;
      tick();
   endtask

   // Filler model: mode 0 nominal (llenando ISSUE+2..+4, lleno at +4),
   // mode 1 fills forever without finishing, mode 2 finishes without ever filling.
   task automatic fillerCycle(input int mode);
      if (startfill) begin
         since = 0;
         if (np < 8) begin
            pulseCyc[np]     = cyc;
            unitsAtPulse[np] = int'(units_done);
         end
         np++;
      end else if (since >= 0) begin
         since++;
      end
      llenando  = (mode != 2) && (since >= 2) && ((mode == 1) || (since <= 4));
      llenoFlag = (mode != 1) && (since == 4);
      if (llenoFlag) lastLleno = cyc;
      if (batch_done) begin
         doneCount++;
         if (doneCyc < 0) doneCyc = cyc;
         unitsAtDone = int'(units_done);
      end
      if ((seq_state == 3'b010) && (waitEnter < 0)) waitEnter = cyc;
      if (fault && (faultCyc < 0)) faultCyc = cyc;
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      batchSize = 8'd0;
`ifdef FILL_SEQ_PAUSE_EN
      pause     = 1'b0;
`endif
      resetModel();
      tick();
      tick();
      checkOutput("reset_state", seq_state, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_startfill", startfill, 0);
      checkOutput("reset_done", batch_done, 0);
      checkOutput("reset_fault", fault, 0);
      checkOutput("reset_units", units_done, 0);
      rst = 1'b0;
      tick();

      // Nominal batch of three units
      resetModel();
      applyStimulus(1'b1, 1'b0, 8'd3);
      start = 1'b0;
      checkOutput("b3_issue_state", seq_state, 1);
      checkOutput("b3_busy", busy, 1);
      for (int i = 0; i < 30; i++) fillerCycle(0);
      checkOutput("b3_pulses", np, 3);
      checkOutput("b3_space1", pulseCyc[1] - pulseCyc[0], 7);
      checkOutput("b3_space2", pulseCyc[2] - pulseCyc[1], 7);
      checkOutput("b3_units_p0", unitsAtPulse[0], 0);
      checkOutput("b3_units_p1", unitsAtPulse[1], 1);
      checkOutput("b3_units_p2", unitsAtPulse[2], 2);
      checkOutput("b3_done_lat", doneCyc - lastLleno, 1);
      checkOutput("b3_done_cnt", doneCount, 1);
      checkOutput("b3_done_units", unitsAtDone, 3);
      checkOutput("b3_end_busy", busy, 0);
      checkOutput("b3_end_state", seq_state, 0);
      checkOutput("b3_end_units", units_done, 3);

      // Zero-size batch goes straight to DONE
      resetModel();
      applyStimulus(1'b1, 1'b0, 8'd0);
      start = 1'b0;
      checkOutput("b0_state", seq_state, 4);
      checkOutput("b0_done", batch_done, 1);
      checkOutput("b0_startfill", startfill, 0);
      checkOutput("b0_units", units_done, 0);
      tick();
      checkOutput("b0_idle", seq_state, 0);
      checkOutput("b0_done_off", batch_done, 0);

      // Timeout: filler never completes
      resetModel();
      applyStimulus(1'b1, 1'b0, 8'd2);
      start = 1'b0;
      for (int i = 0; i < 30; i++) fillerCycle(1);
      llenando = 1'b0;
      checkOutput("to_latency", faultCyc - waitEnter, 16);
      checkOutput("to_fault", fault, 1);
      checkOutput("to_state", seq_state, 5);
      checkOutput("to_busy", busy, 0);
      checkOutput("to_pulses", np, 1);
      applyStimulus(1'b1, 1'b0, 8'd1);
      checkOutput("to_start_ignored", fault, 1);
      applyStimulus(1'b0, 1'b1, 8'd0);
      abort = 1'b0;
      checkOutput("to_abort_state", seq_state, 0);
      checkOutput("to_abort_fault", fault, 0);

      // Protocol error on second unit: lleno_flag with no llenando
      resetModel();
      applyStimulus(1'b1, 1'b0, 8'd2);
      start = 1'b0;
      for (int i = 0; i < 20; i++) fillerCycle((np >= 2) ? 2 : 0);
      llenando  = 1'b0;
      llenoFlag = 1'b0;
      checkOutput("pe_fault", fault, 1);
      checkOutput("pe_units", units_done, 1);
      checkOutput("pe_pulses", np, 2);
      applyStimulus(1'b0, 1'b1, 8'd0);
      abort = 1'b0;
      checkOutput("pe_abort_state", seq_state, 0);
      checkOutput("pe_abort_units", units_done, 1);

      // Abort in GAP after unit 2, with a stray start mid-batch
      resetModel();
      applyStimulus(1'b1, 1'b0, 8'd5);
      for (int i = 0; i < 30; i++) begin
         if (i < 3) begin
            start     = 1'b1;
            batchSize = 8'd1;
         end else begin
            start = 1'b0;
         end
         if ((seq_state == 3'b011) && (units_done == 8'd2)) begin
            found = 1;
            break;
         end
         fillerCycle(0);
      end
      checkOutput("ab_reached_gap", found, 1);
      llenando  = 1'b0;
      llenoFlag = 1'b0;
      applyStimulus(1'b0, 1'b1, 8'd0);
      abort = 1'b0;
      checkOutput("ab_state", seq_state, 0);
      checkOutput("ab_units", units_done, 2);
      checkOutput("ab_startfill", startfill, 0);
      checkOutput("ab_busy", busy, 0);
      np = 0;
      for (int i = 0; i < 10; i++) fillerCycle(0);
      checkOutput("ab_no_more_pulses", np, 0);

      // Asynchronous reset during the second unit's WAIT
      resetModel();
      applyStimulus(1'b1, 1'b0, 8'd3);
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if ((seq_state == 3'b010) && (units_done == 8'd1)) begin
            found = 1;
            break;
         end
         fillerCycle(0);
      end
      checkOutput("rs_reached_wait", found, 1);
      llenando  = 1'b0;
      llenoFlag = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("rs_state", seq_state, 0);
      checkOutput("rs_busy", busy, 0);
      checkOutput("rs_units", units_done, 0);
      checkOutput("rs_startfill", startfill, 0);
      tick();
      rst = 1'b0;
      tick();

`ifdef FILL_SEQ_PAUSE_EN
      // Pause held for ten cycles at the start of GAP stretches the spacing by ten
      begin
         int pauseLeft;
         int pauseStarted;
         pauseLeft    = 0;
         pauseStarted = 0;
         resetModel();
         applyStimulus(1'b1, 1'b0, 8'd2);
         start = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if ((seq_state == 3'b011) && (pauseStarted == 0)) begin
               pauseStarted = 1;
               pauseLeft    = 10;
            end
            pause = (pauseLeft > 0);
            if (pauseLeft > 0) pauseLeft--;
            if (pause) checkOutput("pz_busy", busy, 1);
            fillerCycle(0);
         end
         pause = 1'b0;
         checkOutput("pz_spacing", pulseCyc[1] - pulseCyc[0], 17);
         checkOutput("pz_units", units_done, 2);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
